fibo_stream_checker: RTL and testbench

Consumer end of the Fibonacci generator's stream interface. Each cycle it samples the generator's 8-bit term output and drives the generator's 1-bit control input. It locks onto the sequence from two consecutive terms, then predicts each following term as the mod-256 sum of the previous two and flags the first mismatch. It sits beside the generator in regression and bring-up builds as a self-checking monitor and pacing source.

---
 rtl/fibo_stream_checker.sv | 151 +++++++++++++++
 tb/tb_fibo_stream_checker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fibo_stream_checker.sv
// fibo_stream_checker
// Consumer-side monitor for the Fibonacci generator stream. It locks onto two
// consecutive terms, predicts every following term as the mod-256 sum of the
// previous two, and flags the first mismatch (sticky until rst). In TRACK it
// also paces the generator: after every PAUSE_PERIOD checked terms it raises
// the pause control for one cycle.
// Optional build macro: FIBO_CHK_MISMATCH_LOG_EN -- when defined, __out4 latches
// {expected, actual} of the first mismatch; when undefined, __out4 is 16'h0000.
module fibo_stream_checker #(
  parameter int SKIP         = 0,
  parameter int PAUSE_PERIOD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  __in0,
  output logic        __out0,
  output logic        __out1,
  output logic [15:0] __out2,
  output logic        __out3,
  output logic [15:0] __out4
);

  typedef enum logic [2:0] {
    stSkip  = 3'd0,
    stAcq0  = 3'd1,
    stAcq1  = 3'd2,
    stTrack = 3'd3,
    stFail  = 3'd4
  } state_t;

  // Last index of the skip window and of the pause period; only meaningful
  // when the corresponding feature is enabled.
  localparam logic [7:0] SKIP_LAST  = (SKIP > 0) ? 8'(SKIP - 1) : 8'd0;
  localparam logic [7:0] PAUSE_LAST = (PAUSE_PERIOD > 0) ? 8'(PAUSE_PERIOD - 1) : 8'd0;
  localparam bit         PAUSE_EN   = (PAUSE_PERIOD > 0);
  localparam state_t     RST_STATE  = (SKIP > 0) ? stSkip : stAcq0;

  // Term arithmetic: plain 8-bit sum, carry dropped (mod 256 by construction).
  function automatic logic [7:0] modSum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  // Saturating increment for the checked-term count.
  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state;
  logic [7:0]  skipCnt;
  logic [7:0]  pauseCnt;
  logic [7:0]  p1;
  logic [7:0]  p2;
  logic        pauseQ;
  logic        errQ;
  logic [15:0] cntQ;
  logic        lockQ;
  logic [7:0]  expected;
  logic        sampleOk;

  assign expected = modSum8(p2, p1);
  assign sampleOk = (__in0 == expected);

  // Main sequencer: acquisition, tracking, pacing and error capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RST_STATE;
      skipCnt  <= 8'd0;
      pauseCnt <= 8'd0;
      p1       <= 8'd0;
      p2       <= 8'd0;
      pauseQ   <= 1'b0;
      errQ     <= 1'b0;
      cntQ     <= 16'd0;
      lockQ    <= 1'b0;
    end else begin
      // The pause control is a single-cycle pulse unless re-armed below.
      pauseQ <= 1'b0;
      case (state)
        stSkip: begin
          if (skipCnt == SKIP_LAST) begin
            state <= stAcq0;
          end else begin
            skipCnt <= skipCnt + 8'd1;
          end
        end
        stAcq0: begin
          p2    <= __in0;
          state <= stAcq1;
        end
        stAcq1: begin
          p1    <= __in0;
          state <= stTrack;
          lockQ <= 1'b1;
        end
        stTrack: begin
          // While pause is shown, the generator answers with a filler sample.
          if (!pauseQ) begin
            if (sampleOk) begin
              p2   <= p1;
              p1   <= __in0;
              cntQ <= satInc16(cntQ);
              if (PAUSE_EN) begin
                if (pauseCnt == PAUSE_LAST) begin
                  pauseCnt <= 8'd0;
                  pauseQ   <= 1'b1;
                end else begin
                  pauseCnt <= pauseCnt + 8'd1;
                end
              end
            end else begin
              state <= stFail;
              errQ  <= 1'b1;
              lockQ <= 1'b0;
            end
          end
        end
        stFail: begin
          state <= stFail;
        end
        default: begin
          state <= stFail;
          errQ  <= 1'b1;
          lockQ <= 1'b0;
        end
      endcase
    end
  end

  assign __out0 = pauseQ;
  assign __out1 = errQ;
  assign __out2 = cntQ;
  assign __out3 = lockQ;

`ifdef FIBO_CHK_MISMATCH_LOG_EN
  logic [15:0] logQ;

  // Capture {expected, actual} on the first mismatch; held until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      logQ <= 16'd0;
    end else if (state == stTrack && !pauseQ && !sampleOk) begin
      logQ <= {expected, __in0};
    end
  end

  assign __out4 = logQ;
`else
  assign __out4 = 16'h0000;
`endif

endmodule

// File: tb/tb_fibo_stream_checker.sv
// Directed bench for fibo_stream_checker: three instances (plain, paced,
// skip window). Stimulus pushes the hand-derived outputs expected after each
// clock edge into a scoreboard queue; a monitor pops and compares them.
module tb_fibo_stream_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstv [3];
  logic [7:0]  din  [3];
  logic        po   [3];
  logic        pe   [3];
  logic [15:0] pc   [3];
  logic        pl   [3];
  logic [15:0] pg   [3];

`ifdef FIBO_CHK_MISMATCH_LOG_EN
  localparam logic [15:0] LOG_A = 16'h0304;
  localparam logic [15:0] LOG_B = 16'hE900;
`else
  localparam logic [15:0] LOG_A = 16'h0000;
  localparam logic [15:0] LOG_B = 16'h0000;
`endif

  fibo_stream_checker #(.SKIP(0), .PAUSE_PERIOD(0)) dutPlain (
    .clk(clk), .rst(rstv[0]), .__in0(din[0]),
    .__out0(po[0]), .__out1(pe[0]), .__out2(pc[0]), .__out3(pl[0]), .__out4(pg[0]));

  fibo_stream_checker #(.SKIP(0), .PAUSE_PERIOD(3)) dutPause (
    .clk(clk), .rst(rstv[1]), .__in0(din[1]),
    .__out0(po[1]), .__out1(pe[1]), .__out2(pc[1]), .__out3(pl[1]), .__out4(pg[1]));

  fibo_stream_checker #(.SKIP(13), .PAUSE_PERIOD(0)) dutSkip (
    .clk(clk), .rst(rstv[2]), .__in0(din[2]),
    .__out0(po[2]), .__out1(pe[2]), .__out2(pc[2]), .__out3(pl[2]), .__out4(pg[2]));

  typedef struct {
    int          inst;
    logic        o0;
    logic        o1;
    logic [15:0] o2;
    logic        o3;
    logic [15:0] o4;
  } exp_t;

  exp_t  sbq[$];
  string tagq[$];
  int    nChecks = 0;
  int    nFail   = 0;

  function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  // Drive one sample before the edge and queue the outputs expected after it.
  task automatic step(input int inst, input logic r, input logic [7:0] d,
                      input logic e0, input logic e1, input logic [15:0] e2,
                      input logic e3, input logic [15:0] e4, input string tag);
    exp_t e;
    @(negedge clk);
    rstv[inst] = r;
    din[inst]  = d;
    e.inst = inst; e.o0 = e0; e.o1 = e1; e.o2 = e2; e.o3 = e3; e.o4 = e4;
    sbq.push_back(e);
    tagq.push_back(tag);
  endtask

  // Monitor: after every rising edge, compare whatever has been queued.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(posedge clk);
      #1;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        t = tagq.pop_front();
        chk({t, ".pause"}, {15'd0, po[e.inst]}, {15'd0, e.o0});
        chk({t, ".err"},   {15'd0, pe[e.inst]}, {15'd0, e.o1});
        chk({t, ".count"}, pc[e.inst],          e.o2);
        chk({t, ".lock"},  {15'd0, pl[e.inst]}, {15'd0, e.o3});
        chk({t, ".log"},   pg[e.inst],          e.o4);
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rstv[i] = 1'b1;
      din[i]  = 8'd0;
    end

    // Plain: reset state, then 1,1,2,3,5,8,13,21.
    step(0, 1, 8'd0,   0, 0, 16'd0, 0, 16'd0, "rst0");
    step(0, 0, 8'd1,   0, 0, 16'd0, 0, 16'd0, "fibAcq0");
    step(0, 0, 8'd1,   0, 0, 16'd0, 1, 16'd0, "fibAcq1");
    step(0, 0, 8'd2,   0, 0, 16'd1, 1, 16'd0, "fib2");
    step(0, 0, 8'd3,   0, 0, 16'd2, 1, 16'd0, "fib3");
    step(0, 0, 8'd5,   0, 0, 16'd3, 1, 16'd0, "fib5");
    step(0, 0, 8'd8,   0, 0, 16'd4, 1, 16'd0, "fib8");
    step(0, 0, 8'd13,  0, 0, 16'd5, 1, 16'd0, "fib13");
    step(0, 0, 8'd21,  0, 0, 16'd6, 1, 16'd0, "fib21");

    // Wrap: 233+121 = 98 mod 256.
    step(0, 1, 8'd0,   0, 0, 16'd0, 0, 16'd0, "wrapRst");
    step(0, 0, 8'd144, 0, 0, 16'd0, 0, 16'd0, "wrap144");
    step(0, 0, 8'd233, 0, 0, 16'd0, 1, 16'd0, "wrap233");
    step(0, 0, 8'd121, 0, 0, 16'd1, 1, 16'd0, "wrap121");
    step(0, 0, 8'd98,  0, 0, 16'd2, 1, 16'd0, "wrap98");

    // Mismatch: 1,1,2,4,7 -> fail on 4 (expected 3).
    step(0, 1, 8'd0,   0, 0, 16'd0, 0, 16'd0, "misRst");
    step(0, 0, 8'd1,   0, 0, 16'd0, 0, 16'd0, "mis1a");
    step(0, 0, 8'd1,   0, 0, 16'd0, 1, 16'd0, "mis1b");
    step(0, 0, 8'd2,   0, 0, 16'd1, 1, 16'd0, "mis2");
    step(0, 0, 8'd4,   0, 1, 16'd1, 0, LOG_A, "mis4");
    step(0, 0, 8'd7,   0, 1, 16'd1, 0, LOG_A, "mis7");
    step(0, 0, 8'd12,  0, 1, 16'd1, 0, LOG_A, "misHold");

    // Mid-TRACK reset at count 5, then reacquire from 5,5.
    step(0, 1, 8'd0,   0, 0, 16'd0, 0, 16'd0, "midRst0");
    step(0, 0, 8'd0,   0, 0, 16'd0, 0, 16'd0, "mid0");
    step(0, 0, 8'd1,   0, 0, 16'd0, 1, 16'd0, "mid1");
    step(0, 0, 8'd1,   0, 0, 16'd1, 1, 16'd0, "mid1b");
    step(0, 0, 8'd2,   0, 0, 16'd2, 1, 16'd0, "mid2");
    step(0, 0, 8'd3,   0, 0, 16'd3, 1, 16'd0, "mid3");
    step(0, 0, 8'd5,   0, 0, 16'd4, 1, 16'd0, "mid5");
    step(0, 0, 8'd8,   0, 0, 16'd5, 1, 16'd0, "mid8");
    step(0, 1, 8'd13,  0, 0, 16'd0, 0, 16'd0, "midRst1");
    step(0, 0, 8'd5,   0, 0, 16'd0, 0, 16'd0, "re5a");
    step(0, 0, 8'd5,   0, 0, 16'd0, 1, 16'd0, "re5b");
    step(0, 0, 8'd10,  0, 0, 16'd1, 1, 16'd0, "re10");
    step(0, 0, 8'd15,  0, 0, 16'd2, 1, 16'd0, "re15");
    step(0, 0, 8'd25,  0, 0, 16'd3, 1, 16'd0, "re25");

    // Paced: PAUSE_PERIOD=3, 8'hFF fills each pause-response cycle; then a
    // mismatch on the last term of a period (0 instead of 233).
    step(1, 1, 8'd0,   0, 0, 16'd0,  0, 16'd0, "pRst");
    step(1, 0, 8'd0,   0, 0, 16'd0,  0, 16'd0, "pAcq0");
    step(1, 0, 8'd1,   0, 0, 16'd0,  1, 16'd0, "pAcq1");
    step(1, 0, 8'd1,   0, 0, 16'd1,  1, 16'd0, "p1");
    step(1, 0, 8'd2,   0, 0, 16'd2,  1, 16'd0, "p2");
    step(1, 0, 8'd3,   1, 0, 16'd3,  1, 16'd0, "p3");
    step(1, 0, 8'hFF,  0, 0, 16'd3,  1, 16'd0, "pFill1");
    step(1, 0, 8'd5,   0, 0, 16'd4,  1, 16'd0, "p5");
    step(1, 0, 8'd8,   0, 0, 16'd5,  1, 16'd0, "p8");
    step(1, 0, 8'd13,  1, 0, 16'd6,  1, 16'd0, "p13");
    step(1, 0, 8'hFF,  0, 0, 16'd6,  1, 16'd0, "pFill2");
    step(1, 0, 8'd21,  0, 0, 16'd7,  1, 16'd0, "p21");
    step(1, 0, 8'd34,  0, 0, 16'd8,  1, 16'd0, "p34");
    step(1, 0, 8'd55,  1, 0, 16'd9,  1, 16'd0, "p55");
    step(1, 0, 8'hFF,  0, 0, 16'd9,  1, 16'd0, "pFill3");
    step(1, 0, 8'd89,  0, 0, 16'd10, 1, 16'd0, "p89");
    step(1, 0, 8'd144, 0, 0, 16'd11, 1, 16'd0, "p144");
    step(1, 0, 8'd0,   0, 1, 16'd11, 0, LOG_B, "pBad");
    step(1, 0, 8'hFF,  0, 1, 16'd11, 0, LOG_B, "pFailHold");

    // Skip window of 13, interrupted once by reset to prove it restarts.
    step(2, 1, 8'd0,   0, 0, 16'd0, 0, 16'd0, "sRst0");
    for (int i = 0; i < 5; i++)
      step(2, 0, 8'(i * 7 + 3), 0, 0, 16'd0, 0, 16'd0, "sJunkA");
    step(2, 1, 8'd0,   0, 0, 16'd0, 0, 16'd0, "sRst1");
    for (int i = 0; i < 13; i++)
      step(2, 0, 8'(i * 29 + 1), 0, 0, 16'd0, 0, 16'd0, "sJunkB");
    step(2, 0, 8'd0,   0, 0, 16'd0, 0, 16'd0, "sAcq0");
    step(2, 0, 8'd1,   0, 0, 16'd0, 1, 16'd0, "sAcq1");
    step(2, 0, 8'd1,   0, 0, 16'd1, 1, 16'd0, "s1");
    step(2, 0, 8'd2,   0, 0, 16'd2, 1, 16'd0, "s2");
    step(2, 0, 8'd3,   0, 0, 16'd3, 1, 16'd0, "s3");

    @(negedge clk);
    @(negedge clk);
    nChecks++;
    if (sbq.size() != 0) begin
      nFail++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
